mov_issue_ctrl: RTL and testbench

- Initiator side of the register-move handshake.
- Accepts decoded instruction words into a small FIFO and issues MOV commands (opcode, destination and source register addresses) to the move executor.
- Waits for the executor's active-low completion flag (ctr2 = 0), then retires the instruction.
- Sits between instruction decode and the move executor; drops illegal opcodes and flags executor timeouts.

---
 rtl/mov_issue_ctrl.sv | 135 +++++++++++++
 tb/tb_mov_issue_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mov_issue_ctrl.sv
// Initiator side of the register-move handshake: buffers decoded instructions,
// issues MOV commands to the move executor and retires them on its active-low completion flag.
module mov_issue_ctrl #(
  parameter int         DEPTH_LOG2 = 2,
  parameter int         MIN_WAIT   = 3,
  parameter int         TIMEOUT    = 15,
  parameter logic [3:0] MOV_OP     = 4'b1011
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       instr_valid,
  input  logic [9:0] instr,
  output logic       instr_ready,
  output logic [3:0] ctr1,
  output logic [2:0] radd1,
  output logic [2:0] radd2,
  input  logic       ctr2,
  output logic       busy,
  output logic       retired,
  output logic       illegal,
  output logic       err_timeout,
  output logic [7:0] retire_cnt
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = $clog2(TIMEOUT);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ISSUE  = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_RETIRE = 2'd3;

  logic [9:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;
  logic [9:0]            head;
  logic [1:0]            state;
  logic [CW-1:0]         wait_cnt;

  assign full        = (count == (DEPTH_LOG2+1)'(DEPTH));
  assign empty       = (count == '0);
  assign instr_ready = !full;
  assign push        = instr_valid && !full;
  assign pop         = (state == S_IDLE) && !empty;
  assign head        = mem[rd_ptr];
  assign busy        = (state != S_IDLE) || !empty;

  // Storage needs no reset: flushing the pointers and count empties the buffer.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= instr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Completion is only trusted once the executor has had MIN_WAIT cycles to
  // drop a stale flag left over from the previous move.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      wait_cnt    <= '0;
      ctr1        <= 4'b0000;
      radd1       <= 3'd0;
      radd2       <= 3'd0;
      retired     <= 1'b0;
      illegal     <= 1'b0;
      err_timeout <= 1'b0;
      retire_cnt  <= 8'd0;
    end else begin
      retired <= 1'b0;
      illegal <= 1'b0;
      ctr1    <= 4'b0000;
      case (state)
        S_IDLE: begin
          if (pop) begin
            if (head[9:6] == MOV_OP) begin
              ctr1  <= MOV_OP;
              radd1 <= head[5:3];
              radd2 <= head[2:0];
              state <= S_ISSUE;
            end else begin
              illegal <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          wait_cnt <= '0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt + 1'b1;
          if ((wait_cnt >= CW'(MIN_WAIT - 1)) && !ctr2) begin
            retired    <= 1'b1;
            retire_cnt <= retire_cnt + 8'd1;
            state      <= S_RETIRE;
          end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
            err_timeout <= 1'b1;
            state       <= S_IDLE;
          end
        end
        S_RETIRE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mov_issue_ctrl.sv
// Bench for mov_issue_ctrl: directed scenarios plus random traffic, with an executor stand-in
// driving ctr2 from per-MOV plans and a scoreboard checking issue/retire/illegal/timeout events.
module tb_mov_issue_ctrl;

  localparam logic [3:0] MOV_OP   = 4'b1011;
  localparam int         MIN_WAIT = 3;
  localparam int         TIMEOUT  = 15;

  logic       clk = 1'b0;
  logic       rst;
  logic       instr_valid;
  logic [9:0] instr;
  logic       instr_ready;
  logic [3:0] ctr1;
  logic [2:0] radd1;
  logic [2:0] radd2;
  logic       ctr2;
  logic       busy;
  logic       retired;
  logic       illegal;
  logic       err_timeout;
  logic [7:0] retire_cnt;

  mov_issue_ctrl #(
    .DEPTH_LOG2(2),
    .MIN_WAIT  (MIN_WAIT),
    .TIMEOUT   (TIMEOUT),
    .MOV_OP    (MOV_OP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .instr_valid(instr_valid),
    .instr      (instr),
    .instr_ready(instr_ready),
    .ctr1       (ctr1),
    .radd1      (radd1),
    .radd2      (radd2),
    .ctr2       (ctr2),
    .busy       (busy),
    .retired    (retired),
    .illegal    (illegal),
    .err_timeout(err_timeout),
    .retire_cnt (retire_cnt)
  );

  always #5 clk = ~clk;

  // kind: 0 = MOV that retires after lat cycles from its issue cycle, 1 = MOV that times out, 2 = illegal drop
  typedef struct {
    int       kind;
    logic [2:0] dst;
    logic [2:0] src;
    int       lat;
  } exp_t;

  typedef struct {
    bit glitch;
    int done_at;
  } plan_t;

  exp_t  exp_q[$];
  plan_t plan_q[$];
  int    n_checks  = 0;
  int    n_fail    = 0;
  int    model_cnt = 0;
  bit    model_err = 1'b0;
  bit    pending   = 1'b0;
  exp_t  cur;
  exp_t  mon_e;
  int    cyc = 0;
  plan_t ex_plan;
  bit    ex_active = 1'b0;
  int    ex_k = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at t=%0t", name, actual, expected, $time);
    end
  endtask

  // Executor holds ctr2 low in WAIT cycle k when this is true
  function automatic bit plan_low(input plan_t p, input int k);
    return (p.glitch && k == 0) || (k >= p.done_at);
  endfunction

  // Reference: the first WAIT cycle at or after MIN_WAIT-1 with ctr2 low retires;
  // WAIT cycle k is k+1 cycles after the issue cycle, the retire pulse one cycle later.
  function automatic exp_t model_mov(input logic [2:0] d, input logic [2:0] s, input plan_t p);
    exp_t e;
    e.kind = 1;
    e.dst  = d;
    e.src  = s;
    e.lat  = 0;
    for (int k = 0; k < TIMEOUT; k++) begin
      if (k >= MIN_WAIT - 1 && plan_low(p, k)) begin
        e.kind = 0;
        e.lat  = k + 2;
        return e;
      end
    end
    return e;
  endfunction

  // Executor stand-in: follows the next plan whenever a command appears, noise otherwise
  always @(negedge clk) begin
    if (rst) begin
      ex_active = 1'b0;
      ctr2      = 1'b1;
    end else if (ctr1 != 4'b0000) begin
      if (plan_q.size() > 0) begin
        ex_plan   = plan_q.pop_front();
        ex_active = 1'b1;
      end else begin
        ex_active = 1'b0;
      end
      ex_k = 0;
      ctr2 = 1'($urandom_range(0, 1));
    end else if (ex_active) begin
      ctr2 = !plan_low(ex_plan, ex_k);
      ex_k++;
      if (ex_k >= TIMEOUT) ex_active = 1'b0;
    end else begin
      ctr2 = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents an event
  always @(negedge clk) begin
    if (rst) begin
      pending = 1'b0;
    end else begin
      if (pending) cyc++;
      if (illegal) begin
        if (exp_q.size() == 0) begin
          checkOutput("illegal_unexpected", illegal, 0);
        end else begin
          mon_e = exp_q.pop_front();
          checkOutput("illegal_pulse", illegal, (mon_e.kind == 2));
        end
      end
      if (ctr1 != 4'b0000) begin
        if (pending) checkOutput("issue_overlap", ctr1, 0);
        if (exp_q.size() == 0) begin
          checkOutput("issue_unexpected", ctr1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e.kind == 2) begin
            checkOutput("expected_illegal_got_issue", ctr1, 0);
          end else begin
            checkOutput("issue_opcode", ctr1, MOV_OP);
            checkOutput("issue_radd1", radd1, mon_e.dst);
            checkOutput("issue_radd2", radd2, mon_e.src);
            cur     = mon_e;
            pending = 1'b1;
            cyc     = 0;
          end
        end
      end
      if (pending && cyc > 0) begin
        if (cyc == 1) begin
          checkOutput("ctr1_one_cycle", ctr1, 0);
          checkOutput("radd1_hold", radd1, cur.dst);
          checkOutput("radd2_hold", radd2, cur.src);
        end
        if (cur.kind == 0) begin
          if (cyc < cur.lat && retired) checkOutput("retire_early", retired, 0);
          if (cyc == cur.lat) begin
            checkOutput("retire_pulse", retired, 1);
            model_cnt = (model_cnt + 1) % 256;
          end
          if (cyc == cur.lat + 1) begin
            checkOutput("retire_one_cycle", retired, 0);
            checkOutput("retire_cnt", retire_cnt, model_cnt);
            pending = 1'b0;
          end
        end else begin
          if (retired) checkOutput("retire_on_timeout", retired, 0);
          if (cyc == TIMEOUT) checkOutput("err_before_timeout", err_timeout, model_err);
          if (cyc == TIMEOUT + 1) begin
            model_err = 1'b1;
            checkOutput("err_timeout", err_timeout, 1);
            checkOutput("retire_cnt_timeout", retire_cnt, model_cnt);
            pending = 1'b0;
          end
        end
      end else if (!pending && retired) begin
        checkOutput("retire_unexpected", retired, 0);
      end
    end
  end

  task automatic doReset();
    @(posedge clk);
    #1;
    rst         = 1'b1;
    instr_valid = 1'b0;
    exp_q.delete();
    plan_q.delete();
    model_cnt = 0;
    model_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_ctr1", ctr1, 0);
    checkOutput("rst_radd1", radd1, 0);
    checkOutput("rst_radd2", radd2, 0);
    checkOutput("rst_retired", retired, 0);
    checkOutput("rst_illegal", illegal, 0);
    checkOutput("rst_err", err_timeout, 0);
    checkOutput("rst_cnt", retire_cnt, 0);
    checkOutput("rst_ready", instr_ready, 1);
    checkOutput("rst_busy", busy, 0);
  endtask

  // Called at a negedge; returns at a negedge with instr_valid low
  task automatic applyStimulus(input logic [3:0] op, input logic [2:0] d, input logic [2:0] s,
                               input bit glitch, input int done_at, output int stall);
    bit    ok;
    plan_t p;
    instr       = {op, d, s};
    instr_valid = 1'b1;
    stall       = 0;
    ok          = 1'b0;
    for (int t = 0; t < 400 && !ok; t++) begin
      ok = instr_ready;
      @(posedge clk);
      if (!ok) begin
        stall++;
        @(negedge clk);
      end
    end
    if (!ok) begin
      checkOutput("push_timeout", instr_ready, 1);
    end else if (op == MOV_OP) begin
      p.glitch  = glitch;
      p.done_at = done_at;
      plan_q.push_back(p);
      exp_q.push_back(model_mov(d, s, p));
    end else begin
      exp_q.push_back('{kind: 2, dst: 3'd0, src: 3'd0, lat: 0});
    end
    @(negedge clk);
    instr_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 600 && (exp_q.size() > 0 || pending); t++) @(negedge clk);
    checkOutput("drain_timeout", exp_q.size() + int'(pending), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got hang, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int st;
    logic [3:0] op;
    rst         = 1'b1;
    instr_valid = 1'b0;
    instr       = 10'd0;
    ctr2        = 1'b1;
    doReset();

    // Single MOV with the completion flag already low
    applyStimulus(MOV_OP, 3'd2, 3'd5, 1'b0, 0, st);
    drain();

    // Fill the FIFO behind a slow move
    applyStimulus(MOV_OP, 3'd1, 3'd2, 1'b0, 10, st);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(MOV_OP, 3'(i), 3'(7 - i), 1'b0, 0, st);
      checkOutput("fill_no_stall", st, 0);
    end
    checkOutput("ready_when_full", instr_ready, 0);
    checkOutput("busy_when_full", busy, 1);
    applyStimulus(MOV_OP, 3'd6, 3'd3, 1'b0, 1, st);
    checkOutput("push_stalled_when_full", (st > 0), 1);
    drain();

    // Illegal opcode dropped, following MOV issues
    applyStimulus(4'b0010, 3'd1, 3'd1, 1'b0, 0, st);
    applyStimulus(MOV_OP, 3'd4, 3'd6, 1'b0, 0, st);
    drain();

    // Executor never completes, then a normal move
    applyStimulus(MOV_OP, 3'd7, 3'd7, 1'b0, 99, st);
    applyStimulus(MOV_OP, 3'd3, 3'd0, 1'b0, 1, st);
    drain();
    checkOutput("err_sticky", err_timeout, 1);

    // Stale low in WAIT cycle 0, real completion at cycle 4
    applyStimulus(MOV_OP, 3'd5, 3'd1, 1'b1, 4, st);
    drain();

    // Reset while waiting with two entries queued
    applyStimulus(MOV_OP, 3'd1, 3'd1, 1'b0, 99, st);
    applyStimulus(MOV_OP, 3'd2, 3'd2, 1'b0, 0, st);
    applyStimulus(MOV_OP, 3'd3, 3'd3, 1'b0, 0, st);
    repeat (4) @(negedge clk);
    doReset();
    applyStimulus(MOV_OP, 3'd6, 3'd4, 1'b0, 0, st);
    drain();

    // Random traffic
    for (int n = 0; n < 150; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      if ($urandom_range(0, 3) == 0) begin
        op = 4'($urandom_range(0, 15));
        if (op == MOV_OP) op = 4'b0000;
      end else begin
        op = MOV_OP;
      end
      applyStimulus(op, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                    1'($urandom_range(0, 1)),
                    ($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(0, 8)), st);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
